// File: rtl/wb_irq_ctrl_if.sv
// rtl/wb_irq_ctrl_if.sv - pipelined Wishbone bus bundle for the interrupt controller
interface wb_irq_ctrl_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [4:0]  adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, stall_o
  );
endinterface

// File: rtl/wb_irq_ctrl.sv
// rtl/wb_irq_ctrl.sv - Wishbone interrupt controller with edge/level sources and claim
module wb_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_irq_ctrl_if.slave       bus,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] irq_d_q, irq_d_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               req, wr, rd;
  logic [2:0]         reg_idx;
  logic [31:0]        wmask;
  logic [NUM_IRQ-1:0] wdat_n, wm_n;
  logic [NUM_IRQ-1:0] active, claim_onehot, w1c, claim_clr, edge_set;
  logic [31:0]        claim32, pend32, en32, mode32, raw32;
  logic               unused_bits;

  assign req     = bus.cyc_i & bus.stb_i;
  assign wr      = req & bus.we_i;
  assign rd      = req & ~bus.we_i;
  assign reg_idx = bus.adr_i[4:2];
  assign wmask   = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}}, {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
  assign wdat_n  = bus.dat_i[NUM_IRQ-1:0];
  assign wm_n    = wmask[NUM_IRQ-1:0];

  assign unused_bits = &{1'b0, bus.adr_i[1:0], bus.dat_i, wmask};

  assign active   = pending_q & enable_q;
  assign edge_set = irq_i & ~irq_d_q;

  // Lowest-numbered active source: descending scan so the smallest index is written last
  always_comb begin
    claim32      = '0;
    claim_onehot = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (active[k]) begin
        claim32         = 32'(k + 1);
        claim_onehot    = '0;
        claim_onehot[k] = 1'b1;
      end
    end
  end

  // Zero-extend register views so bits at NUM_IRQ and above read as 0
  always_comb begin
    pend32 = '0;
    en32   = '0;
    mode32 = '0;
    raw32  = '0;
    pend32[NUM_IRQ-1:0] = pending_q;
    en32[NUM_IRQ-1:0]   = enable_q;
    mode32[NUM_IRQ-1:0] = mode_q;
    raw32[NUM_IRQ-1:0]  = irq_i;
  end

  // Next-state: register writes, pending update (set beats clear), registered read data
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr && reg_idx == 3'd1) enable_d = (enable_q & ~wm_n) | (wdat_n & wm_n);
    if (wr && reg_idx == 3'd2) mode_d   = (mode_q & ~wm_n) | (wdat_n & wm_n);

    w1c       = (wr && reg_idx == 3'd0) ? (wdat_n & wm_n) : '0;
    claim_clr = (rd && reg_idx == 3'd3) ? claim_onehot : '0;

    // Edge sources latch rising edges; level sources simply follow the line
    pending_d = (mode_q & (edge_set | (pending_q & ~(w1c | claim_clr))))
              | (~mode_q & irq_i);
    irq_d_d   = irq_i;
    ack_d     = req;

    rdata_d = '0;
    if (rd) begin
      case (reg_idx)
        3'd0:    rdata_d = pend32;
        3'd1:    rdata_d = en32;
        3'd2:    rdata_d = mode32;
        3'd3:    rdata_d = claim32;
        3'd4:    rdata_d = raw32;
        default: rdata_d = '0;
      endcase
    end
  end

  // State registers; reset also drops any request accepted in the reset cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      irq_d_q   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_d_q   <= irq_d_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.dat_o   = rdata_q;
  assign bus.stall_o = 1'b0;
  assign irq_o       = |(pending_q & enable_q);

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb/tb_wb_irq_ctrl.sv - vector table plus randomized model check for wb_irq_ctrl
module tb_wb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq = '0;
  logic       irq_o;

  wb_irq_ctrl_if bus();

  wb_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .irq_i (irq),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    bit          rst;
    bit          req;
    bit          we;
    bit [4:0]    adr;
    bit [3:0]    sel;
    bit [31:0]   dat;
    bit [7:0]    irq;
    bit          exp_ack;
    bit          chk_dat;
    bit [31:0]   exp_dat;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  bit [7:0] m_pend = '0, m_en = '0, m_mode = '0, m_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string n, input bit r, input bit rq, input bit w,
                             input bit [4:0] a, input bit [3:0] s, input bit [31:0] d,
                             input bit [7:0] i, input bit ea, input bit cd,
                             input bit [31:0] ed, input bit ei);
    vec_t t;
    t.name = n; t.rst = r; t.req = rq; t.we = w; t.adr = a; t.sel = s; t.dat = d;
    t.irq = i; t.exp_ack = ea; t.chk_dat = cd; t.exp_dat = ed; t.exp_irq = ei;
    return t;
  endfunction

  task automatic drive(input bit r, input bit rq, input bit w, input bit [4:0] a,
                       input bit [3:0] s, input bit [31:0] d, input bit [7:0] i);
    rst       = r;
    bus.cyc_i = rq;
    bus.stb_i = rq;
    bus.we_i  = w;
    bus.adr_i = a;
    bus.sel_i = s;
    bus.dat_i = d;
    irq       = i;
  endtask

  // Spec-level model: one call per clock with this cycle's inputs, returns post-edge outputs
  task automatic model_step(input bit r, input bit rq, input bit w, input bit [4:0] a,
                            input bit [3:0] s, input bit [31:0] d, input bit [7:0] i,
                            output bit e_ack, output bit [31:0] e_dat, output bit e_irq);
    int idx;
    int claim;
    bit [7:0] np;
    idx = int'(a) / 4;
    claim = 0;
    for (int k = 0; k < 8; k++)
      if (claim == 0 && m_pend[k] && m_en[k]) claim = k + 1;
    e_ack = rq && !r;
    e_dat = 0;
    if (e_ack && !w) begin
      case (idx)
        0: e_dat = {24'd0, m_pend};
        1: e_dat = {24'd0, m_en};
        2: e_dat = {24'd0, m_mode};
        3: e_dat = claim;
        4: e_dat = {24'd0, i};
        default: e_dat = 0;
      endcase
    end
    if (r) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (!m_mode[k]) np[k] = i[k];
        else begin
          bit clr, rose;
          clr  = (e_ack && w && idx == 0 && s[k/8] && d[k]) || (e_ack && !w && idx == 3 && claim == k + 1);
          rose = i[k] && !m_prev[k];
          np[k] = rose || (m_pend[k] && !clr);
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (e_ack && w && idx == 1 && s[k/8]) m_en[k] = d[k];
        if (e_ack && w && idx == 2 && s[k/8]) m_mode[k] = d[k];
      end
      m_pend = np;
      m_prev = i;
    end
    e_irq = |(m_pend & m_en);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    // name rst req we adr sel dat irq | ack chk dat irq
    tbl.push_back(v("reset",        1,0,0,5'h00,4'hF,32'h0, 8'h00, 0,1,32'h0, 0));
    tbl.push_back(v("e_mode",       0,1,1,5'h08,4'hF,32'h1, 8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("e_en",         0,1,1,5'h04,4'hF,32'h1, 8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("e_pulse",      0,0,0,5'h00,4'h0,32'h0, 8'h01, 0,0,32'h0, 1));
    tbl.push_back(v("e_hold",       0,0,0,5'h00,4'h0,32'h0, 8'h00, 0,0,32'h0, 1));
    tbl.push_back(v("e_rd_pend",    0,1,0,5'h00,4'h0,32'h0, 8'h00, 1,1,32'h1, 1));
    tbl.push_back(v("e_w1c",        0,1,1,5'h00,4'hF,32'h1, 8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("l_mode",       0,1,1,5'h08,4'hF,32'h0, 8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("l_en",         0,1,1,5'h04,4'hF,32'h4, 8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("l_high",       0,0,0,5'h00,4'h0,32'h0, 8'h04, 0,0,32'h0, 1));
    tbl.push_back(v("l_w1c",        0,1,1,5'h00,4'hF,32'h4, 8'h04, 1,0,32'h0, 1));
    tbl.push_back(v("l_rd_pend",    0,1,0,5'h00,4'h0,32'h0, 8'h04, 1,1,32'h4, 1));
    tbl.push_back(v("l_low",        0,0,0,5'h00,4'h0,32'h0, 8'h00, 0,0,32'h0, 0));
    tbl.push_back(v("c_mode",       0,1,1,5'h08,4'hF,32'h2A,8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("c_en",         0,1,1,5'h04,4'hF,32'h2A,8'h00, 1,0,32'h0, 0));
    tbl.push_back(v("c_edges",      0,0,0,5'h00,4'h0,32'h0, 8'h2A, 0,0,32'h0, 1));
    tbl.push_back(v("c_claim1",     0,1,0,5'h0C,4'h0,32'h0, 8'h2A, 1,1,32'h2, 1));
    tbl.push_back(v("c_claim2",     0,1,0,5'h0C,4'h0,32'h0, 8'h2A, 1,1,32'h4, 1));
    tbl.push_back(v("c_claim3",     0,1,0,5'h0C,4'h0,32'h0, 8'h2A, 1,1,32'h6, 0));
    tbl.push_back(v("c_claim4",     0,1,0,5'h0C,4'h0,32'h0, 8'h2A, 1,1,32'h0, 0));
    tbl.push_back(v("c_pend0",      0,1,0,5'h00,4'h0,32'h0, 8'h2A, 1,1,32'h0, 0));
    tbl.push_back(v("x_low",        0,0,0,5'h00,4'h0,32'h0, 8'h00, 0,0,32'h0, 0));
    tbl.push_back(v("x_collide",    0,1,1,5'h00,4'hF,32'h2, 8'h02, 1,0,32'h0, 1));
    tbl.push_back(v("x_rd_pend",    0,1,0,5'h00,4'h0,32'h0, 8'h02, 1,1,32'h2, 1));
    tbl.push_back(v("x_w1c",        0,1,1,5'h00,4'hF,32'h2, 8'h02, 1,0,32'h0, 0));
    for (int n = 0; n < 4; n++)
      tbl.push_back(v($sformatf("b_b2b%0d", n), 0,1,0,5'h04,4'h0,32'h0, 8'h02, 1,1,32'h2A, 0));
    tbl.push_back(v("b_wr_sel1",    0,1,1,5'h04,4'h1,32'hFF,8'h02, 1,0,32'h0, 0));
    tbl.push_back(v("b_rd_en",      0,1,0,5'h04,4'h0,32'h0, 8'h02, 1,1,32'hFF, 0));
    tbl.push_back(v("b_unmapped",   0,1,0,5'h14,4'h0,32'h0, 8'h02, 1,1,32'h0, 0));
    tbl.push_back(v("b_wr_sel_e",   0,1,1,5'h04,4'hE,32'h0, 8'h02, 1,0,32'h0, 0));
    tbl.push_back(v("b_rd_en2",     0,1,0,5'h04,4'h0,32'h0, 8'h02, 1,1,32'hFF, 0));
    tbl.push_back(v("b_raw",        0,1,0,5'h10,4'h0,32'h0, 8'h02, 1,1,32'h2, 0));
    tbl.push_back(v("r_mode",       0,1,1,5'h08,4'hF,32'h1, 8'h02, 1,0,32'h0, 0));
    tbl.push_back(v("r_edge",       0,0,0,5'h00,4'h0,32'h0, 8'h01, 0,0,32'h0, 1));
    tbl.push_back(v("r_reset",      1,1,0,5'h00,4'h0,32'h0, 8'h01, 0,1,32'h0, 0));
    tbl.push_back(v("r_release",    0,0,0,5'h00,4'h0,32'h0, 8'h01, 0,0,32'h0, 0));
    tbl.push_back(v("r_rd_pend",    0,1,0,5'h00,4'h0,32'h0, 8'h01, 1,1,32'h1, 0));
    tbl.push_back(v("r_rd_en",      0,1,0,5'h04,4'h0,32'h0, 8'h01, 1,1,32'h0, 0));
    tbl.push_back(v("r_rd_mode",    0,1,0,5'h08,4'h0,32'h0, 8'h01, 1,1,32'h0, 0));
    tbl.push_back(v("d_mode",       0,1,1,5'h08,4'hF,32'h1, 8'h01, 1,0,32'h0, 0));
    tbl.push_back(v("d_latched",    0,0,0,5'h00,4'h0,32'h0, 8'h00, 0,0,32'h0, 0));
    tbl.push_back(v("d_enable",     0,1,1,5'h04,4'hF,32'h1, 8'h00, 1,0,32'h0, 1));
    tbl.push_back(v("d_w1c",        0,1,1,5'h00,4'hF,32'h1, 8'h00, 1,0,32'h0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, tbl[i].irq);
      @(posedge clk); #1;
      check({tbl[i].name, "/ack"}, {31'd0, bus.ack_o}, {31'd0, tbl[i].exp_ack});
      check({tbl[i].name, "/irq_o"}, {31'd0, irq_o}, {31'd0, tbl[i].exp_irq});
      check({tbl[i].name, "/stall"}, {31'd0, bus.stall_o}, 32'd0);
      if (tbl[i].chk_dat) check({tbl[i].name, "/dat"}, bus.dat_o, tbl[i].exp_dat);
    end

    // Single request followed by idle: exactly one ack cycle
    drive(0, 1, 0, 5'h04, 4'h0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("single/ack1", {31'd0, bus.ack_o}, 32'd1);
    @(posedge clk); #1;
    check("single/ack0", {31'd0, bus.ack_o}, 32'd0);

    // Randomized traffic against the model, starting from reset
    begin
      bit [7:0] cur_irq;
      bit e_ack, e_irq;
      bit [31:0] e_dat;
      cur_irq = '0;
      for (int c = 0; c < 800; c++) begin
        bit r, rq, w;
        bit [4:0] a;
        bit [3:0] s;
        bit [31:0] d;
        r  = (c == 0) || ($urandom_range(0, 63) == 0);
        rq = ($urandom_range(0, 3) != 0);
        w  = $urandom_range(0, 1) == 1;
        a  = 5'($urandom_range(0, 31));
        s  = 4'($urandom);
        d  = $urandom;
        if ($urandom_range(0, 2) == 0) cur_irq = 8'($urandom);
        drive(r, rq, w, a, s, d, cur_irq);
        model_step(r, rq, w, a, s, d, cur_irq, e_ack, e_dat, e_irq);
        @(posedge clk); #1;
        check($sformatf("rnd%0d/ack", c), {31'd0, bus.ack_o}, {31'd0, e_ack});
        check($sformatf("rnd%0d/irq_o", c), {31'd0, irq_o}, {31'd0, e_irq});
        if (e_ack && !w) check($sformatf("rnd%0d/dat", c), bus.dat_o, e_dat);
      end
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_irq_ctrl.md
WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources, legal range 1..32.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all flops on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port cyc_i, input, 1, Wishbone pipelined bus cycle.
REQ-005 SHALL have port stb_i, input, 1, request strobe.
REQ-006 SHALL have port we_i, input, 1, 1 = write.
REQ-007 SHALL have port adr_i, input, 5, byte address; bits [1:0] ignored.
REQ-008 SHALL have port sel_i, input, 4, byte enables for writes.
REQ-009 SHALL have port dat_i, input, 32, write data.
REQ-010 SHALL have port dat_o, output, 32, read data, valid with ack_o.
REQ-011 SHALL have port ack_o, output, 1, request acknowledge.
REQ-012 SHALL have port stall_o, output, 1, tied 0.
REQ-013 SHALL have port irq_i, input, NUM_IRQ, source lines synchronous to clk_i; bit 0 is wired to the timer irq.
REQ-014 SHALL have port irq_o, output, 1, aggregated interrupt to the CPU.

Function
REQ-015 SHALL map registers: 0x00 PENDING (R, W1C), 0x04 ENABLE (RW), 0x08 MODE (RW; 1 = edge, 0 = level), 0x0C CLAIM (R), 0x10 RAW (R; current irq_i).
REQ-016 SHALL accept a request on every cycle with cyc_i & stb_i, and assert ack_o exactly one cycle later, with back-to-back requests giving back-to-back acks.
REQ-017 SHALL return read data registered, with dat_o valid in the ack_o cycle and bits at NUM_IRQ and above read as 0.
REQ-018 SHALL honour sel_i per byte on writes, where a byte with sel_i = 0 is left unchanged.
REQ-019 SHALL acknowledge unmapped addresses (0x14-0x1C) normally: reads return 0, writes are ignored.
REQ-020 SHALL keep irq_d, a register holding irq_i from the previous cycle.
REQ-021 SHALL, for an edge source, set pending[k] at the clock edge where irq_i[k] = 1 and irq_d[k] = 0.
REQ-022 SHALL, for a level source, load pending[k] with irq_i[k] every cycle, ignoring W1C and claim.
REQ-023 SHALL clear pending[k] of an edge source when PENDING is written with bit k = 1 (write-1-to-clear).
REQ-024 SHALL, on a CLAIM read, return the lowest k where pending[k] & enable[k] = 1, encoded as k + 1, or 0 if there is none.
REQ-025 SHALL, on a CLAIM read of an edge source, clear pending[k] of that source in the same cycle the value is captured.
REQ-026 SHALL let set win when a new edge coincides with a W1C or claim clear of the same bit, so pending stays 1.
REQ-027 SHALL latch pending for disabled sources, so enabling later raises irq_o.
REQ-028 SHALL drive irq_o = OR over k of (pending[k] & enable[k]), decoded only from registers with no combinational path from irq_i or the bus.
REQ-029 SHALL give a latency of exactly 1 cycle from irq_i[k] rising (source enabled) to irq_o high.
REQ-030 SHALL apply MODE writes from the next cycle, with pending left as is at the switch.

Reset
REQ-031 SHALL, with rst_i high at a clock edge, clear pending, enable, mode, irq_d, ack_o and dat_o, so that irq_o = 0.
REQ-032 SHALL abort, without ack, any request accepted in the cycle rst_i is high.
REQ-033 SHALL treat an irq_i line that is high at the first edge after reset release as a rising edge for edge sources, because irq_d resets to 0.

Verification
REQ-034 SHALL cover edge latch: MODE = 0x1, ENABLE = 0x1, 1-cycle pulse on irq_i[0] -> irq_o = 1 from next cycle; PENDING reads 0x1; after W1C of 0x1, irq_o = 0 next cycle.
REQ-035 SHALL cover level: MODE = 0, ENABLE = 0x4, irq_i[2] held high -> irq_o = 1; W1C of 0x4 has no effect; irq_i[2] low -> irq_o = 0 one cycle later.
REQ-036 SHALL cover claim: edge sources 1, 3 and 5 pending and enabled -> CLAIM reads 2, 4, 6, then 0; PENDING = 0 afterwards.
REQ-037 SHALL cover collision: W1C of bit 1 issued in the same cycle as a new rising edge on irq_i[1] -> PENDING bit 1 stays 1.
REQ-038 SHALL cover bus: 4 back-to-back reads of 0x04 -> 4 consecutive acks; write 0xFF with sel = 4'b0001 to ENABLE -> reads 0xFF; unmapped read -> 0 with ack.
REQ-039 SHALL cover reset mid-operation: pending and enable set, rst_i pulsed for 1 cycle -> all registers 0 and irq_o = 0; irq_i[0] held high across reset in edge mode -> PENDING bit 0 = 1 after release.
